// File: rtl/comp_minmax_tracker_pkg.sv
// Shared types for the comparator-driven min/max tracker: compare flags,
// tracker FSM states and the unsigned compare helper.
package comp_pkg;

  localparam int unsigned CMP_W = 8;

  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
  } cmp_flags_t;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic cmp_flags_t cmp_unsigned(input logic [CMP_W-1:0] a,
                                              input logic [CMP_W-1:0] b);
    cmp_flags_t f;
    f.gt = (a > b);
    f.eq = (a == b);
    f.lt = (a < b);
    return f;
  endfunction

endpackage

// File: rtl/comp_minmax_tracker_if.sv
// Sample-in / result-out handshake bundle for comp_minmax_tracker.
interface comp_minmax_tracker_if #(
  parameter  int unsigned FRAME_LEN = 16,
  localparam int unsigned IDX_W     = $clog2(FRAME_LEN)
);
  import comp_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [CMP_W-1:0] in_data;
  logic             clr;
  logic             out_valid;
  logic             out_ready;
  logic [CMP_W-1:0] out_max;
  logic [CMP_W-1:0] out_min;
  logic [IDX_W-1:0] out_max_idx;
  logic [IDX_W:0]   out_max_cnt;

  modport master (
    output in_valid, in_data, clr, out_ready,
    input  in_ready, out_valid, out_max, out_min, out_max_idx, out_max_cnt
  );

  modport slave (
    input  in_valid, in_data, clr, out_ready,
    output in_ready, out_valid, out_max, out_min, out_max_idx, out_max_cnt
  );

endinterface

// File: rtl/comp_minmax_tracker_cmp8.sv
// Combinational 8-bit unsigned magnitude compare producing gt/eq/lt flags.
module cmp8_flags
  import comp_pkg::*;
(
  input  logic [CMP_W-1:0] a,
  input  logic [CMP_W-1:0] b,
  output cmp_flags_t       flags
);

  assign flags = cmp_unsigned(a, b);

endmodule

// File: rtl/comp_minmax_tracker.sv
// Per-frame streaming max/min tracker: accumulates FRAME_LEN samples, then
// holds max, min, first-max index and max count until the consumer accepts.
module comp_minmax_tracker
  import comp_pkg::*;
#(
  parameter int unsigned FRAME_LEN = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  comp_minmax_tracker_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CMP_W-1:0] max_q, max_d;
  logic [CMP_W-1:0] min_q, min_d;
  logic [IDX_W-1:0] max_idx_q, max_idx_d;
  logic [IDX_W:0]   cnt_q, cnt_d;
  logic             in_ready;
  logic             out_valid;
  logic             accept;
  cmp_flags_t       vs_max;
  cmp_flags_t       vs_min;

  cmp8_flags u_cmp_max (
    .a     (bus.in_data),
    .b     (max_q),
    .flags (vs_max)
  );

  cmp8_flags u_cmp_min (
    .a     (bus.in_data),
    .b     (min_q),
    .flags (vs_min)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    max_d     = max_q;
    min_d     = min_q;
    max_idx_d = max_idx_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;

    case (state_q)
      ACC: begin
        // clr blocks acceptance so the aborted frame cannot absorb this sample
        in_ready = !bus.clr;
        accept   = bus.in_valid && in_ready;
        if (bus.clr) begin
          idx_d = '0;
        end else if (accept) begin
          if (idx_q == '0) begin
            max_d     = bus.in_data;
            min_d     = bus.in_data;
            max_idx_d = '0;
            cnt_d     = {{IDX_W{1'b0}}, 1'b1};
          end else begin
            if (vs_max.gt) begin
              max_d     = bus.in_data;
              max_idx_d = idx_q;
              cnt_d     = {{IDX_W{1'b0}}, 1'b1};
            end else if (vs_max.eq) begin
              cnt_d = cnt_q + 1'b1;
            end
            if (vs_min.lt) begin
              min_d = bus.in_data;
            end
          end
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = HOLD;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (bus.out_ready) begin
          state_d = ACC;
        end
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ACC;
      idx_q     <= '0;
      max_q     <= '0;
      min_q     <= '1;
      max_idx_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      max_q     <= max_d;
      min_q     <= min_d;
      max_idx_q <= max_idx_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.out_max     = max_q;
  assign bus.out_min     = min_q;
  assign bus.out_max_idx = max_idx_q;
  assign bus.out_max_cnt = cnt_q;

endmodule

// File: tb/tb_comp_minmax_tracker.sv
// Scoreboard bench for comp_minmax_tracker: directed frames plus randomized
// traffic with clr pulses and random output backpressure.
module tb_comp_minmax_tracker;
  import comp_pkg::*;

  localparam int unsigned FRAME_LEN = 16;
  localparam int unsigned IDX_W     = $clog2(FRAME_LEN);

  typedef struct {
    logic [7:0]       mx;
    logic [7:0]       mn;
    logic [IDX_W-1:0] idx;
    logic [IDX_W:0]   cnt;
  } res_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  comp_minmax_tracker_if #(.FRAME_LEN(FRAME_LEN)) bus ();

  comp_minmax_tracker #(.FRAME_LEN(FRAME_LEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   checks   = 0;
  int   failures = 0;
  res_t exp_q[$];
  logic [7:0] frame_q[$];
  int   done_cnt  = 0;
  int   taken_cnt = 0;
  bit   rand_ready = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: frame statistics straight from the definition of max/min/first/count.
  function automatic res_t ref_model(input logic [7:0] s[$]);
    res_t r;
    r.mx  = 8'h00;
    r.mn  = 8'hFF;
    r.idx = '0;
    r.cnt = '0;
    foreach (s[i]) begin
      if (s[i] > r.mx) r.mx = s[i];
      if (s[i] < r.mn) r.mn = s[i];
    end
    for (int unsigned i = 0; i < s.size(); i++) begin
      if (s[i] == r.mx) begin
        if (r.cnt == 0) r.idx = IDX_W'(i);
        r.cnt = r.cnt + 1'b1;
      end
    end
    return r;
  endfunction

  // Input-side model: tracks what the block should accept and queues results.
  always @(negedge clk) begin : in_mon
    bit holding;
    if (!rst_n) begin
      frame_q.delete();
      exp_q.delete();
      done_cnt <= 0;
    end else begin
      holding = (done_cnt != taken_cnt);
      chk("in_ready", 32'(bus.in_ready), 32'(!holding && !bus.clr));
      if (!holding) begin
        if (bus.clr) begin
          frame_q.delete();
        end else if (bus.in_valid) begin
          frame_q.push_back(bus.in_data);
          if (frame_q.size() == FRAME_LEN) begin
            exp_q.push_back(ref_model(frame_q));
            frame_q.delete();
            done_cnt <= done_cnt + 1;
          end
        end
      end
    end
  end

  // Output monitor: compares presented results against the scoreboard.
  always @(negedge clk) begin : out_mon
    bit   pend;
    res_t e;
    if (!rst_n) begin
      taken_cnt <= 0;
    end else begin
      pend = (done_cnt != taken_cnt);
      chk("out_valid", 32'(bus.out_valid), 32'(pend));
      if (bus.out_valid && pend && taken_cnt < exp_q.size()) begin
        e = exp_q[taken_cnt];
        chk("out_max", 32'(bus.out_max), 32'(e.mx));
        chk("out_min", 32'(bus.out_min), 32'(e.mn));
        chk("out_max_idx", 32'(bus.out_max_idx), 32'(e.idx));
        chk("out_max_cnt", 32'(bus.out_max_cnt), 32'(e.cnt));
        if (bus.out_ready) taken_cnt <= taken_cnt + 1;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Presents one sample until accepted; returns the number of stall cycles.
  task automatic send(input logic [7:0] d, output int waited);
    bit acc;
    acc    = 1'b0;
    waited = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (!acc && waited < 200) begin
      @(negedge clk);
      acc = bus.in_ready;
      cyc();
      if (!acc) waited++;
    end
    bus.in_valid = 1'b0;
    chk("send_accepted", 32'(acc), 32'd1);
  endtask

  task automatic send_frame_rand();
    int w;
    for (int unsigned i = 0; i < FRAME_LEN; i++) send(8'($urandom), w);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, "_out_max"}, 32'(bus.out_max), 32'h00);
    chk({tag, "_out_min"}, 32'(bus.out_min), 32'hFF);
    chk({tag, "_out_max_idx"}, 32'(bus.out_max_idx), 32'd0);
    chk({tag, "_out_max_cnt"}, 32'(bus.out_max_cnt), 32'd0);
  endtask

  initial begin
    int w;
    int r;
    logic [7:0] pat[16];
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.clr       = 1'b0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    check_reset_values("reset");

    // Reset mid-frame, then a clean frame.
    for (int unsigned i = 0; i < 5; i++) send(8'($urandom), w);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    check_reset_values("midreset");
    send_frame_rand();
    cyc();

    // Ascending 0..15.
    for (int unsigned i = 0; i < 16; i++) send(8'(i), w);
    chk("asc_max", 32'(bus.out_max), 32'd15);
    chk("asc_min", 32'(bus.out_min), 32'd0);
    chk("asc_idx", 32'(bus.out_max_idx), 32'd15);
    chk("asc_cnt", 32'(bus.out_max_cnt), 32'd1);

    // 3,9,9,1,9 then eleven 2s.
    pat = '{8'd3, 8'd9, 8'd9, 8'd1, 8'd9, 8'd2, 8'd2, 8'd2,
            8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2};
    for (int unsigned i = 0; i < 16; i++) send(pat[i], w);
    chk("rep_max", 32'(bus.out_max), 32'd9);
    chk("rep_idx", 32'(bus.out_max_idx), 32'd1);
    chk("rep_cnt", 32'(bus.out_max_cnt), 32'd3);
    chk("rep_min", 32'(bus.out_min), 32'd1);

    // All equal: count reaches FRAME_LEN without wrapping.
    for (int unsigned i = 0; i < 16; i++) send(8'h80, w);
    chk("flat_max", 32'(bus.out_max), 32'h80);
    chk("flat_min", 32'(bus.out_min), 32'h80);
    chk("flat_idx", 32'(bus.out_max_idx), 32'd0);
    chk("flat_cnt", 32'(bus.out_max_cnt), 32'd16);
    cyc();

    // Backpressure: 10 held cycles with a sample waiting, release on the 11th.
    bus.out_ready = 1'b0;
    send_frame_rand();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h5A;
    for (int unsigned i = 0; i < 10; i++) cyc();
    bus.out_ready = 1'b1;
    cyc();
    send(8'h5A, w);
    chk("bp_next_accept_wait", 32'(w), 32'd0);
    for (int unsigned i = 1; i < FRAME_LEN; i++) send(8'($urandom), w);
    cyc();

    // clr after 7 samples, with a sample offered in the same cycle.
    for (int unsigned i = 0; i < 7; i++) send(8'($urandom_range(16, 200)), w);
    bus.clr      = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h33;
    cyc();
    bus.clr      = 1'b0;
    bus.in_valid = 1'b0;
    send(8'hFF, w);
    for (int unsigned i = 1; i < 16; i++) send(8'h00, w);
    chk("clr_max", 32'(bus.out_max), 32'hFF);
    chk("clr_idx", 32'(bus.out_max_idx), 32'd0);
    chk("clr_min", 32'(bus.out_min), 32'h00);
    cyc();

    // Randomized traffic: gaps, clr pulses (including during hold), random out_ready.
    rand_ready = 1'b1;
    for (int unsigned n = 0; n < 700; n++) begin
      r = $urandom_range(0, 99);
      if (r < 8) begin
        cyc();
      end else if (r < 11) begin
        bus.clr      = 1'b1;
        bus.in_valid = 1'($urandom);
        bus.in_data  = 8'($urandom);
        cyc();
        bus.clr      = 1'b0;
        bus.in_valid = 1'b0;
      end else if (r < 55) begin
        send(8'($urandom_range(0, 7)), w);
      end else begin
        send(8'($urandom), w);
      end
    end

    // Drain any pending result.
    rand_ready    = 1'b0;
    bus.out_ready = 1'b1;
    for (int unsigned i = 0; i < 50 && done_cnt != taken_cnt; i++) cyc();
    chk("drained", 32'(done_cnt - taken_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
